// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI mode-0 byte receiver.
// Byte width, status counter width and receive-frame states live here.
package spi_rx_pkg;

   localparam int BITS_PER_BYTE    = 8;
   localparam int BYTE_COUNT_WIDTH = 16;
   localparam int BIT_CNT_WIDTH    = $clog2(BITS_PER_BYTE);

   typedef logic [BITS_PER_BYTE-1:0]    spi_byte_t;
   typedef logic [BYTE_COUNT_WIDTH-1:0] byte_count_t;
   typedef logic [BIT_CNT_WIDTH-1:0]    bit_cnt_t;

   typedef enum logic {
      RX_IDLE   = 1'b0,
      RX_ACTIVE = 1'b1
   } rx_state_e;

   localparam bit_cnt_t LAST_BIT = bit_cnt_t'(BITS_PER_BYTE - 1);

   // Saturating increment so the debugger never sees a wrapped count.
   function automatic byte_count_t sat_inc(input byte_count_t c);
      return (c == '1) ? c : c + byte_count_t'(1);
   endfunction

endpackage

// File: rtl/spi_byte_receiver_if.sv
// Received-byte stream: show-ahead data with valid/ready handshake.
// master drives data_out/data_valid; slave drives data_ready.
interface spi_byte_receiver_if;
   import spi_rx_pkg::*;

   spi_byte_t data_out;
   logic      data_valid;
   logic      data_ready;

   modport master (output data_out, output data_valid, input data_ready);
   modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/spi_rx_fifo.sv
// Show-ahead byte FIFO; write lands one edge after push, head visible when !empty.
// Push while full is dropped unless a pop happens in the same cycle.
module spi_rx_fifo
   import spi_rx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  spi_byte_t push_dat,
   input  logic      pop,
   output spi_byte_t pop_dat,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   spi_byte_t   mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   // Extra pointer bit separates the wrapped (full) case from equal (empty).
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave: synchronises SCK/CS/MOSI, assembles MSB-first bytes into a FIFO.
// Byte visible SYNC_STAGES+2 edges after the 8th SCK high is sampled; full FIFO drops and flags.
module spi_byte_receiver
   import spi_rx_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk_in,
   input  logic                       reset_n,
   input  logic                       spi_clk,
   input  logic                       spi_cs,
   input  logic                       spi_mosi,
   spi_byte_receiver_if.master        rx,
   output logic                       frame_start,
   output logic                       frame_end,
   output logic                       busy,
   output byte_count_t                byte_count,
   output logic                       overflow_err,
   output logic                       frame_err,
   input  logic                       err_clear
);

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_d;
   logic                   cs_d;
   logic                   sck_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sck_rise;
   logic                   cs_fall;
   logic                   cs_rise;

   rx_state_e   state;
   rx_state_e   state_nxt;
   logic        start_nxt;
   logic        end_nxt;
   logic        capture;
   logic        byte_done;
   bit_cnt_t    bit_cnt;
   spi_byte_t   shift_q;
   spi_byte_t   next_byte;
   logic        push_q;
   spi_byte_t   push_byte_q;

   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   logic        drop;
   spi_byte_t   head;

   // CS resets high so a released reset never looks like a frame boundary.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sck_d     <= sck_s;
         cs_d      <= cs_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s && !sck_d;
   assign cs_fall  = !cs_s && cs_d;
   assign cs_rise  = cs_s && !cs_d;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state <= RX_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_nxt = 1'b0;
      end_nxt   = 1'b0;
      capture   = 1'b0;
      case (state)
         RX_IDLE: begin
            if (cs_fall) begin
               state_nxt = RX_ACTIVE;
               start_nxt = 1'b1;
            end
         end
         RX_ACTIVE: begin
            if (cs_rise) begin
               state_nxt = RX_IDLE;
               end_nxt   = 1'b1;
            end else if (sck_rise && !cs_s) begin
               capture = 1'b1;
            end
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   assign busy      = (state == RX_ACTIVE);
   assign byte_done = capture && (bit_cnt == LAST_BIT);
   assign next_byte = {shift_q[BITS_PER_BYTE-2:0], mosi_s};

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt     <= '0;
         shift_q     <= '0;
         byte_count  <= '0;
         push_q      <= 1'b0;
         push_byte_q <= '0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         frame_start <= start_nxt;
         frame_end   <= end_nxt;
         push_q      <= byte_done;
         if (byte_done) begin
            push_byte_q <= next_byte;
         end
         if (start_nxt) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_count <= '0;
         end else if (end_nxt) begin
            bit_cnt <= '0;
            shift_q <= '0;
         end else if (capture) begin
            shift_q <= next_byte;
            bit_cnt <= bit_cnt + bit_cnt_t'(1);
            if (byte_done) begin
               byte_count <= sat_inc(byte_count);
            end
         end
      end
   end

   // A simultaneous pop frees the slot, so only a full FIFO without a pop drops.
   assign pop  = rx.data_valid && rx.data_ready;
   assign drop = push_q && fifo_full && !pop;

   // Error sets take priority over a coincident clear.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         overflow_err <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         overflow_err <= drop || (overflow_err && !err_clear);
         frame_err    <= (end_nxt && (bit_cnt != '0)) || (frame_err && !err_clear);
      end
   end

   spi_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk_in),
      .rst_n    (reset_n),
      .push     (push_q),
      .push_dat (push_byte_q),
      .pop      (pop),
      .pop_dat  (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign rx.data_out   = head;
   assign rx.data_valid = !fifo_empty;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed bench for spi_byte_receiver with a queue-based scoreboard on the byte stream.
module tb_spi_byte_receiver;

   localparam int FIFO_DEPTH  = 4;
   localparam int SYNC_STAGES = 2;

   logic        clk_in   = 1'b0;
   logic        reset_n  = 1'b0;
   logic        spi_clk  = 1'b0;
   logic        spi_cs   = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        err_clear = 1'b0;
   logic        frame_start;
   logic        frame_end;
   logic        busy;
   logic [15:0] byte_count;
   logic        overflow_err;
   logic        frame_err;

   spi_byte_receiver_if rx ();

   spi_byte_receiver #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk_in       (clk_in),
      .reset_n      (reset_n),
      .spi_clk      (spi_clk),
      .spi_cs       (spi_cs),
      .spi_mosi     (spi_mosi),
      .rx           (rx.master),
      .frame_start  (frame_start),
      .frame_end    (frame_end),
      .busy         (busy),
      .byte_count   (byte_count),
      .overflow_err (overflow_err),
      .frame_err    (frame_err),
      .err_clear    (err_clear)
   );

   always #5 clk_in = ~clk_in;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   int         e0_cyc   = 0;
   int         cs_e0    = 0;
   int         ce_e0    = 0;
   int         fs_cnt   = 0;
   int         fe_cnt   = 0;
   bit         lat_armed = 1'b0;
   logic       prev_valid = 1'b0;
   logic [7:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk_in) cyc++;

   // Monitor: samples mid-cycle; valid&&ready here means a transfer at the next posedge.
   always @(negedge clk_in) begin
      logic [7:0] exp_b;
      #1;
      if (frame_start) begin
         fs_cnt++;
         chk("frame_start_latency", cyc - cs_e0 + 1, SYNC_STAGES + 1);
      end
      if (frame_end) begin
         fe_cnt++;
         chk("frame_end_latency", cyc - ce_e0 + 1, SYNC_STAGES + 1);
      end
      if (lat_armed && rx.data_valid && !prev_valid) begin
         chk("data_latency", cyc - e0_cyc + 1, SYNC_STAGES + 2);
      end
      prev_valid = rx.data_valid;
      if (rx.data_valid && rx.data_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %0h expected none", rx.data_out);
         end else begin
            exp_b = exp_q.pop_front();
            chk("rx_byte", {24'h0, rx.data_out}, {24'h0, exp_b});
         end
      end
   end

   task automatic start_frame();
      @(negedge clk_in);
      spi_cs = 1'b0;
      cs_e0  = cyc + 1;
      repeat (6) @(negedge clk_in);
   endtask

   task automatic end_frame();
      @(negedge clk_in);
      spi_clk = 1'b0;
      repeat (2) @(negedge clk_in);
      spi_cs = 1'b1;
      ce_e0  = cyc + 1;
      repeat (8) @(negedge clk_in);
   endtask

   // act: 0 none, 1 err_clear on the push edge of the last bit, 2 raise data_ready on it.
   task automatic send_bits(input logic [7:0] b, input int nbits, input bit keep, input int act);
      if (keep) exp_q.push_back(b);
      for (int i = 7; i > 7 - nbits; i--) begin
         @(negedge clk_in);
         spi_clk  = 1'b0;
         spi_mosi = b[i];
         @(negedge clk_in);
         @(negedge clk_in);
         spi_clk = 1'b1;
         if (i == 0) e0_cyc = cyc + 1;
         @(negedge clk_in);
         @(negedge clk_in);
         if (i == 0 && act != 0) begin
            @(negedge clk_in);
            if (act == 1) err_clear = 1'b1;
            else rx.data_ready = 1'b1;
            @(negedge clk_in);
            err_clear = 1'b0;
         end
      end
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         @(negedge clk_in);
         n++;
      end
      chk("drain_remaining", exp_q.size(), 0);
      repeat (3) @(negedge clk_in);
   endtask

   task automatic pulse_clear();
      @(negedge clk_in);
      err_clear = 1'b1;
      @(negedge clk_in);
      err_clear = 1'b0;
      #1;
   endtask

   initial begin
      int fe_before;
      rx.data_ready = 1'b0;
      repeat (3) @(negedge clk_in);
      #1;
      chk("reset_data_valid", rx.data_valid, 0);
      chk("reset_data_out", rx.data_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_byte_count", byte_count, 0);
      chk("reset_overflow", overflow_err, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_pulses", {frame_start, frame_end}, 0);
      @(negedge clk_in);
      reset_n = 1'b1;
      repeat (4) @(negedge clk_in);

      // Single frame A5, 3C with consumer always ready
      rx.data_ready = 1'b1;
      lat_armed = 1'b1;
      start_frame();
      chk("t1_busy", busy, 1);
      send_bits(8'hA5, 8, 1'b1, 0);
      send_bits(8'h3C, 8, 1'b1, 0);
      end_frame();
      drain(50);
      lat_armed = 1'b0;
      chk("t1_byte_count", byte_count, 2);
      chk("t1_frame_starts", fs_cnt, 1);
      chk("t1_frame_ends", fe_cnt, 1);
      chk("t1_busy_after", busy, 0);
      chk("t1_errors", {overflow_err, frame_err}, 0);

      // Back-pressure: six bytes into a four-entry FIFO
      rx.data_ready = 1'b0;
      start_frame();
      for (int b = 1; b <= 6; b++) send_bits(8'(b), 8, (b <= 4), 0);
      end_frame();
      chk("t2_overflow", overflow_err, 1);
      chk("t2_byte_count", byte_count, 6);
      chk("t2_valid_held", rx.data_valid, 1);
      rx.data_ready = 1'b1;
      drain(50);
      chk("t2_exactly_four", rx.data_valid, 0);
      pulse_clear();
      chk("t2_overflow_cleared", overflow_err, 0);

      // Partial byte then a clean frame
      start_frame();
      send_bits(8'hB0, 5, 1'b0, 0);
      end_frame();
      chk("t3_frame_err", frame_err, 1);
      chk("t3_fifo_empty", rx.data_valid, 0);
      chk("t3_byte_count", byte_count, 0);
      start_frame();
      send_bits(8'h7E, 8, 1'b1, 0);
      end_frame();
      drain(50);
      chk("t3_byte_count_after", byte_count, 1);
      chk("t3_frame_err_sticky", frame_err, 1);
      pulse_clear();
      chk("t3_frame_err_cleared", frame_err, 0);

      // Full FIFO with a pop on the same edge as the fifth push
      rx.data_ready = 1'b0;
      start_frame();
      for (int b = 0; b < 4; b++) send_bits(8'h21 + 8'(b), 8, 1'b1, 0);
      send_bits(8'h25, 8, 1'b1, 2);
      end_frame();
      drain(50);
      chk("t4_no_overflow", overflow_err, 0);
      chk("t4_byte_count", byte_count, 5);

      // Clear coincident with an overflow: set wins
      rx.data_ready = 1'b0;
      start_frame();
      for (int b = 0; b < 4; b++) send_bits(8'h31 + 8'(b), 8, 1'b1, 0);
      send_bits(8'h35, 8, 1'b0, 1);
      end_frame();
      chk("t5_set_wins", overflow_err, 1);
      pulse_clear();
      chk("t5_second_clear", overflow_err, 0);
      rx.data_ready = 1'b1;
      drain(50);

      // Reset mid-byte with a byte parked in the FIFO
      rx.data_ready = 1'b0;
      start_frame();
      send_bits(8'h11, 8, 1'b0, 0);
      repeat (4) @(negedge clk_in);
      chk("t6_byte_parked", rx.data_valid, 1);
      send_bits(8'hE0, 3, 1'b0, 0);
      @(negedge clk_in);
      reset_n = 1'b0;
      spi_cs  = 1'b1;
      spi_clk = 1'b0;
      #1;
      fe_before = fe_cnt;
      chk("t6_reset_valid", rx.data_valid, 0);
      chk("t6_reset_data", rx.data_out, 0);
      chk("t6_reset_busy", busy, 0);
      chk("t6_reset_count", byte_count, 0);
      repeat (3) @(negedge clk_in);
      reset_n = 1'b1;
      repeat (12) @(negedge clk_in);
      chk("t6_no_frame_end", fe_cnt, fe_before);
      chk("t6_no_frame_err", frame_err, 0);
      rx.data_ready = 1'b1;
      start_frame();
      send_bits(8'hC3, 8, 1'b1, 0);
      end_frame();
      drain(50);
      chk("t6_byte_count", byte_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_byte_receiver.md
# spi_byte_receiver

SPI mode-0 slave receiver that deserialises MOSI bytes (MSB first) from an external SPI master into a small FIFO with a valid/ready output. It sits between the `gp17`/`gp19`/`gp20` (or `sd_d[0]`/`sd_clk`/`sd_cmd`) pins and the row-data controller in `main`. It is the receive end of the byte stream the SPI master sends one row at a time. It also reports framing, overflow and byte-count status for the debugger.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two and ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flops on `spi_clk`, `spi_cs` and `spi_mosi`; must be ≥ 2.
- `clk_in` input 1: system clock (`clk_root`).
- `reset_n` input 1: asynchronous, active-low reset.
- `spi_clk` input 1: SPI SCK, asynchronous to `clk_in`; idles low (mode 0).
- `spi_cs` input 1: chip select, active low, asynchronous.
- `spi_mosi` input 1: serial data, asynchronous.
- `data_out` output 8: FIFO head byte.
- `data_valid` output 1: FIFO not empty.
- `data_ready` input 1: consumer accepts `data_out` when `data_valid` is also high.
- `frame_start` output 1: one-cycle pulse when CS asserts.
- `frame_end` output 1: one-cycle pulse when CS deasserts.
- `busy` output 1: synchronised CS is asserted (frame in progress).
- `byte_count` output 16: bytes completed in the current or last frame; saturates at 16'hFFFF.
- `overflow_err` output 1: sticky; a completed byte was dropped because the FIFO was full.
- `frame_err` output 1: sticky; CS deasserted with a partial byte.
- `err_clear` input 1: synchronous clear of both sticky errors.

## Operation
- **Synchronisers.** Each asynchronous input passes through `SYNC_STAGES` flops.
  - Reset values: sck 0, cs 1, mosi 0.
  - One further flop on synchronised sck and cs provides edge detection.
- **Frame start.** A falling edge of synchronised CS:
  - pulses `frame_start`;
  - clears the bit counter, the shift register and `byte_count`;
  - sets `busy`.
- **Bit capture.** A rising edge of synchronised SCK while synchronised CS is low shifts synchronised MOSI into the shift register LSB, MSB first. The 3-bit counter increments on each captured bit.
- **Byte completion.** On the 8th bit (counter 7→0 wrap), the assembled byte is pushed and `byte_count` increments.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and `overflow_err` sets.
  - A dropped byte still counts in `byte_count`.
- **Ignored edges.** SCK edges while CS is high are ignored.
- **Frame end.** A rising edge of synchronised CS:
  - pulses `frame_end` and clears `busy`;
  - sets `frame_err` if the bit counter ≠ 0, discards the partial byte, and clears the counter.
- **FIFO.** Show-ahead behaviour.
  - `data_valid` is !empty.
  - A pop occurs when `data_valid && data_ready`.
  - A push and a pop in the same cycle when full both succeed; no overflow is flagged.
  - A push and a pop in the same cycle when empty: the byte is stored and `data_valid` rises the next cycle. There is no bypass.
- **Error clearing.** `err_clear` clears both sticky errors. If an error sets in the same cycle as `err_clear`, the set wins.
- **Reset.** `reset_n` low at any time, including mid-byte or mid-frame:
  - outputs go immediately to reset values;
  - the FIFO empties and partial data is lost;
  - no `frame_end` or `frame_err` is generated.

## Timing
- **Reset values.** `data_out` 8'h00; `data_valid`, `frame_start`, `frame_end`, `busy`, `overflow_err`, `frame_err` all 0; `byte_count` 0.
- **SCK limits.** SCK high and low phases must each be ≥ 2 `clk_in` periods, so `spi_clk` ≤ `clk_in`/4. This matches the master's divide-by-4.
- **MOSI setup.** MOSI changes on SCK falling edges and is stable ≥ 2 `clk_in` periods around each rising edge.
- **Data latency.** `data_valid` rises exactly `SYNC_STAGES`+2 `clk_in` edges after the first `clk_in` edge that samples the 8th `spi_clk` high:
  - `SYNC_STAGES` synchroniser edges;
  - 1 edge-detect/push edge;
  - 1 FIFO flag update edge.
- **Status pulse latency.** `frame_start`/`frame_end` pulse `SYNC_STAGES`+1 edges after the `clk_in` edge that samples the CS transition.
- **Status timing.** `busy` changes on the same edge as the corresponding pulse. Sticky errors set on the push or frame-end edge.
- **Throughput.** One pop per cycle is sustained.

## Structure
- **Package `spi_rx_pkg`:**
  - `BITS_PER_BYTE` = 8;
  - `BYTE_COUNT_WIDTH` = 16;
  - typedef `spi_byte_t` (logic [7:0]).
- **Sub-module `spi_rx_fifo`:** synchronous FIFO (parameter `DEPTH`, 8-bit data, show-ahead) with push/pop/full/empty.
  - Pointers are log2(`DEPTH`)+1 bits wide; the extra bit distinguishes full from empty.
- **Top level:** the synchronisers, edge detection, shift/count logic and status live in `spi_byte_receiver`.

## Test plan
- **Single frame:** CS low, send 8'hA5, 8'h3C at `clk_in`/4, data_ready=1, CS high.
  - Bytes A5 then 3C appear with the specified latency.
  - `byte_count`=2, one `frame_start` and one `frame_end` pulse, no errors.
- **Back-pressure:** data_ready=0, send 6 bytes 01..06 with `FIFO_DEPTH`=4.
  - 01..04 are retained and `overflow_err`=1, `byte_count`=6.
  - Raising data_ready drains exactly 01..04.
- **Partial byte:** CS low, 5 SCK pulses, CS high.
  - `frame_err`=1, FIFO stays empty.
  - The next full frame of 8'h7E delivers 7E correctly.
- **Full push+pop:** fill the FIFO (4 bytes), then hold data_ready=1 as the 5th byte completes.
  - No overflow; all 5 bytes are delivered in order.
- **Error clear:** assert `err_clear` in the same cycle an overflow occurs, so `overflow_err` stays 1; a second `err_clear` sets it to 0.
- **Reset mid-byte:** pulse `reset_n` low after 3 bits.
  - All outputs go to reset values and no `frame_end` is generated.
  - A following fresh frame of 8'hC3 is received correctly.
